// File: rtl/func_equiv_sweeper.sv
// Exhaustive equivalence sweeper: walks every minterm onto vec_out, compares f_a/f_b
// after SETTLE cycles, counts non-don't-care mismatches and records the lowest one.
module func_equiv_sweeper #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [(1<<N_IN)-1:0]   dc_mask,
    output logic [N_IN-1:0]        vec_out,
    input  logic                   f_a,
    input  logic                   f_b,
    output logic                   busy,
    output logic                   done,
    output logic                   equal,
    output logic [N_IN:0]          mismatch_cnt,
    output logic [N_IN-1:0]        first_mismatch,
    output logic                   first_valid
);

    localparam logic [N_IN-1:0] LAST_VEC    = '1;
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t          state_q;
    logic [N_IN-1:0] vec_q;
    logic [3:0]      settle_q;
    logic            busy_q;
    logic            done_q;
    logic            equal_q;
    logic [N_IN:0]   cnt_q;
    logic [N_IN:0]   cnt_d;
    logic [N_IN-1:0] first_q;
    logic            fv_q;
    logic            hit;

    always_comb begin
        hit   = (f_a ^ f_b) & ~dc_mask[vec_q];
        cnt_d = hit ? cnt_q + (N_IN+1)'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vec_q    <= '0;
            settle_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            equal_q  <= 1'b0;
            cnt_q    <= '0;
            first_q  <= '0;
            fv_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= APPLY;
                        vec_q    <= '0;
                        settle_q <= '0;
                        busy_q   <= 1'b1;
                        equal_q  <= 1'b0;
                        cnt_q    <= '0;
                        first_q  <= '0;
                        fv_q     <= 1'b0;
                    end
                end
                APPLY: begin
                    settle_q <= settle_q + 4'd1;
                    if (settle_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    cnt_q <= cnt_d;
                    if (hit && !fv_q) begin
                        first_q <= vec_q;
                        fv_q    <= 1'b1;
                    end
                    // Last minterm: vec_out stays parked here until the next start.
                    if (vec_q == LAST_VEC) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        equal_q <= (cnt_d == '0);
                    end else begin
                        vec_q    <= vec_q + N_IN'(1);
                        settle_q <= '0;
                        state_q  <= APPLY;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_out        = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign equal          = equal_q;
    assign mismatch_cnt   = cnt_q;
    assign first_mismatch = first_q;
    assign first_valid    = fv_q;

endmodule

// File: doc/func_equiv_sweeper.md
Name: func_equiv_sweeper

Overview:
- Sequencer that exhaustively checks two combinational logic functions for equivalence. It drives every input combination (minterm) onto a shared input vector and samples both function outputs.
- It counts mismatches, ignoring don't-care minterms, and reports the first failing minterm.
- Sits in front of the lab's combinational function modules: the SOP/POS pair, or the K-map-minimised vs. NAND-only implementation.

Parameters:
- N_IN, 4, number of function inputs; sweep covers 2**N_IN minterms; vec_out[N_IN-1] is the MSB (A), vec_out[0] is the LSB (D).
- SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  begin a sweep; sampled only in IDLE.
- dc_mask  input  2**N_IN  bit m=1 marks minterm m as don't-care; sampled every SAMPLE cycle, must be held stable during a sweep.
- vec_out  output  N_IN  current minterm applied to both functions.
- f_a  input  1  output of function under test A.
- f_b  input  1  output of function under test B.
- busy  output  1  high while sweeping (states APPLY, SAMPLE).
- done  output  1  one-cycle pulse when the sweep completes.
- equal  output  1  1 when the last sweep found zero mismatches; valid from the done pulse.
- mismatch_cnt  output  N_IN+1  number of non-don't-care minterms where f_a != f_b.
- first_mismatch  output  N_IN  lowest minterm that mismatched.
- first_valid  output  1  first_mismatch holds a real value.

Behaviour:
- Reset values: state IDLE, vec_out=0, busy=0, done=0, equal=0, mismatch_cnt=0, first_mismatch=0, first_valid=0, settle counter=0.
- Reset asserted mid-sweep aborts immediately to the reset values; no done pulse is produced.
- FSM states: IDLE, APPLY, SAMPLE, DONE.
- IDLE:
  - When start=1 at an edge, go to APPLY.
  - On the same edge: vec_out<=0, mismatch_cnt<=0, first_valid<=0, first_mismatch<=0, equal<=0, settle counter<=0.
- APPLY:
  - vec_out is held stable.
  - The settle counter increments each cycle; after SETTLE cycles, go to SAMPLE.
- SAMPLE (exactly 1 cycle):
  - A mismatch is (f_a ^ f_b) & ~dc_mask[vec_out].
  - On a mismatch, mismatch_cnt increments.
  - On a mismatch with first_valid=0, capture first_mismatch<=vec_out and set first_valid<=1.
  - If vec_out == 2**N_IN-1, go to DONE.
  - Otherwise increment vec_out, clear the settle counter, and go to APPLY.
- DONE (1 cycle):
  - done=1, busy=0, equal is driven as (mismatch_cnt==0).
  - Next state is IDLE.
  - start is ignored in DONE.
- Sweep timing:
  - Each minterm takes SETTLE+1 cycles.
  - done is asserted in cycle 1 + 2**N_IN*(SETTLE+1) after the start edge. With defaults that is cycle 33.
- vec_out does not wrap during a sweep. It holds 2**N_IN-1 through DONE and IDLE until the next start.
- Result outputs (equal, mismatch_cnt, first_mismatch, first_valid) hold until the next accepted start.
- start asserted while busy or in DONE has no effect. A level-held start re-triggers a new sweep on the first IDLE cycle.
- mismatch_cnt width N_IN+1 holds the all-mismatch count 2**N_IN without overflow.
- f_a and f_b are only sampled in SAMPLE; their values in other states are don't-care.

Test Plan:
- Equivalence pass: defaults, f_a=f_b=(a&~c)|(b&c)|(~b&~c) of vec_out, dc_mask=0, start pulse.
  -> done at cycle 33; equal=1, mismatch_cnt=0, first_valid=0.
- Single mismatch: f_b = f_a ^ (vec_out==5), dc_mask=0.
  -> equal=0, mismatch_cnt=1, first_mismatch=5, first_valid=1.
- Don't-care masking: same stimulus as the single-mismatch test with dc_mask=16'h0020.
  -> equal=1, mismatch_cnt=0.
- Full mismatch: f_b=~f_a.
  -> mismatch_cnt=16, first_mismatch=0, equal=0.
- start ignored when busy: pulse start again at cycle 10 of a sweep.
  -> exactly one done pulse, at cycle 33; results unchanged.
- Reset mid-sweep: assert rst_n=0 asynchronously at cycle 15.
  -> all outputs return to reset values immediately; no done pulse.
  -> A subsequent start runs a clean full sweep.
